// File: rtl/ir_intf_mc_if.sv
// ---------------------------------------------------------------------------
// ir_intf_mc_if
//
// Signal bundle between the multi-channel IR sensor front end and its
// environment (detector board plus the consumers cmd_proc / inert_intf).
//
// Signals:
//   ir_n          raw active-low detector inputs, asynchronous to clk
//   en_mask       1 = channel enabled
//   force_sample  single-cycle request for an early sample window
//   IR_en         registered emitter enable
//   ir            filtered, active-high channel levels
//   ir_rise       one-cycle pulse per channel when ir goes 0->1
//   ir_fall       one-cycle pulse per channel when ir goes 1->0
//   sample_vld    one-cycle pulse in the cycle the filter results update
//
// Handshake semantics: there is no backpressure anywhere on this bundle.
// sample_vld, ir_rise and ir_fall are pure strobes; a consumer that wants
// them must capture ir / ir_rise / ir_fall in the cycle sample_vld is high.
// force_sample is likewise a fire-and-forget pulse that the front end only
// honours while it is idle between windows.
//
// Modports:
//   master  the IR front end (drives the emitter and the filtered results)
//   slave   the environment (drives detector inputs, mask and requests)
// ---------------------------------------------------------------------------
interface ir_intf_mc_if #(
   parameter int NUM_CH = 3
);

   logic [NUM_CH-1:0] ir_n;
   logic [NUM_CH-1:0] en_mask;
   logic              force_sample;
   logic              IR_en;
   logic [NUM_CH-1:0] ir;
   logic [NUM_CH-1:0] ir_rise;
   logic [NUM_CH-1:0] ir_fall;
   logic              sample_vld;

   modport master (
      input  ir_n,
      input  en_mask,
      input  force_sample,
      output IR_en,
      output ir,
      output ir_rise,
      output ir_fall,
      output sample_vld
   );

   modport slave (
      output ir_n,
      output en_mask,
      output force_sample,
      input  IR_en,
      input  ir,
      input  ir_rise,
      input  ir_fall,
      input  sample_vld
   );

endinterface

// File: rtl/ir_intf_mc.sv
// ---------------------------------------------------------------------------
// ir_intf_mc
//
// Parametrised multi-channel IR sensor interface. A free-running period
// counter duty-cycles the shared emitter enable; at the last cycle of each
// enable window every enabled channel is sampled and passed through a
// consecutive-sample debounce filter. Filtered levels, rise/fall strobes and
// a sample-valid strobe all update on the edge that closes the window.
//
// Parameters:
//   FAST_SIM    1: 512-cycle period, 32-cycle window; 0: use the two below
//   NUM_CH      number of channels, 1..16
//   PERIOD_CYC  sample period in clocks
//   EN_CYC      emitter-on window in clocks, 2 <= EN_CYC < PERIOD_CYC
//   FILT_DEPTH  consecutive disagreeing samples needed to flip an output,
//               1..15
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   bus        ir_intf_mc_if master modport (inputs, emitter, results)
//   dbg_state  current window state: 0 = OFF, 1 = ON, 2 = SAMP
// ---------------------------------------------------------------------------
module ir_intf_mc #(
   parameter bit FAST_SIM   = 1'b1,
   parameter int NUM_CH     = 3,
   parameter int PERIOD_CYC = 500000,
   parameter int EN_CYC     = 25000,
   parameter int FILT_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   ir_intf_mc_if.master       bus,
   output logic [1:0]         dbg_state
);

   // ------------------------------------------------------------------------
   // Effective timing
   // ------------------------------------------------------------------------
   localparam int P  = FAST_SIM ? 512 : PERIOD_CYC;
   localparam int E  = FAST_SIM ? 32  : EN_CYC;
   localparam int CW = $clog2(P);

   // First cycle of the emitter window and the sampling cycle.
   localparam logic [CW-1:0] WIN_START = CW'(P - E);
   localparam logic [CW-1:0] CNT_LAST  = CW'(P - 1);
   localparam logic [3:0]    DEPTH     = 4'(FILT_DEPTH);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_ON   = 2'd1,
      ST_SAMP = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Input synchroniser. Flops reset to 1 so that a channel reads as
   // "no object" until real data has propagated through.
   // ------------------------------------------------------------------------
   logic [NUM_CH-1:0] sync1_q;
   logic [NUM_CH-1:0] sync2_q;
   logic [NUM_CH-1:0] s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= bus.ir_n;
         sync2_q <= sync1_q;
      end
   end

   assign s = ~sync2_q;

   // ------------------------------------------------------------------------
   // Period counter and window state machine
   // ------------------------------------------------------------------------
   state_t          state_q;
   state_t          state_d;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic            ir_en_q;
   logic            ir_en_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         ir_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ir_en_q <= ir_en_d;
      end
   end

   // The state is a pure function of the counter value it accompanies, so
   // both are computed from cnt_d. Decoding IR_en from cnt_d (rather than
   // cnt_q) lets the enable come straight out of a flop while still being
   // aligned with the counter.
   always_comb begin
      cnt_d   = cnt_q + CW'(1);
      state_d = ST_OFF;
      ir_en_d = 1'b0;

      case (state_q)
         ST_OFF: begin
            // An early window is only started from idle; requests while the
            // emitter is already on (or sampling) are dropped.
            if (bus.force_sample) begin
               cnt_d = WIN_START;
            end
         end
         ST_ON: begin
            cnt_d = cnt_q + CW'(1);
         end
         ST_SAMP: begin
            cnt_d = '0;
         end
         default: begin
            cnt_d = '0;
         end
      endcase

      if (cnt_d == CNT_LAST) begin
         state_d = ST_SAMP;
      end else if (cnt_d >= WIN_START) begin
         state_d = ST_ON;
      end else begin
         state_d = ST_OFF;
      end

      ir_en_d = (cnt_d >= WIN_START);
   end

   // ------------------------------------------------------------------------
   // Debounce filter
   //
   // dc counts consecutive samples that disagree with the current output.
   // Any agreeing sample clears it; reaching FILT_DEPTH flips the output and
   // emits the matching edge strobe. Masking a channel clears it silently.
   // ------------------------------------------------------------------------
   logic [NUM_CH-1:0] ir_q;
   logic [NUM_CH-1:0] ir_d;
   logic [NUM_CH-1:0] rise_q;
   logic [NUM_CH-1:0] rise_d;
   logic [NUM_CH-1:0] fall_q;
   logic [NUM_CH-1:0] fall_d;
   logic              vld_q;
   logic [3:0]        dc_q [NUM_CH];
   logic [3:0]        dc_d [NUM_CH];

   always_comb begin
      ir_d   = ir_q;
      rise_d = '0;
      fall_d = '0;
      dc_d   = dc_q;

      if (state_q == ST_SAMP) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (!bus.en_mask[c]) begin
               ir_d[c] = 1'b0;
               dc_d[c] = 4'd0;
            end else if (s[c] == ir_q[c]) begin
               dc_d[c] = 4'd0;
            end else if ((dc_q[c] + 4'd1) == DEPTH) begin
               ir_d[c]   = s[c];
               dc_d[c]   = 4'd0;
               rise_d[c] = s[c];
               fall_d[c] = ~s[c];
            end else begin
               dc_d[c] = dc_q[c] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q   <= '0;
         rise_q <= '0;
         fall_q <= '0;
         vld_q  <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            dc_q[c] <= 4'd0;
         end
      end else begin
         ir_q   <= ir_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         vld_q  <= (state_q == ST_SAMP);
         for (int c = 0; c < NUM_CH; c++) begin
            dc_q[c] <= dc_d[c];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.IR_en      = ir_en_q;
   assign bus.ir         = ir_q;
   assign bus.ir_rise    = rise_q;
   assign bus.ir_fall    = fall_q;
   assign bus.sample_vld = vld_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_ir_intf_mc.sv
// ---------------------------------------------------------------------------
// tb_ir_intf_mc
//
// Bench for ir_intf_mc. Two instances share clock and reset:
//   dut_a  NUM_CH=3, FILT_DEPTH=2 (main scenarios)
//   dut_b  NUM_CH=8, FILT_DEPTH=1 (wide configuration)
// Expected timing comes from period arithmetic on a cycle index; expected
// filter results come from a per-sample reference model of the debounce
// rule working on whole sample vectors.
// ---------------------------------------------------------------------------
module tb_ir_intf_mc;

   localparam int P = 512;
   localparam int E = 32;

   // ------------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   ir_intf_mc_if #(.NUM_CH(3)) bus_a ();
   ir_intf_mc_if #(.NUM_CH(8)) bus_b ();

   logic [1:0] dbg_a;
   logic [1:0] dbg_b;

   ir_intf_mc #(
      .FAST_SIM   (1'b1),
      .NUM_CH     (3),
      .PERIOD_CYC (500000),
      .EN_CYC     (25000),
      .FILT_DEPTH (2)
   ) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_a),
      .dbg_state (dbg_a)
   );

   ir_intf_mc #(
      .FAST_SIM   (1'b1),
      .NUM_CH     (8),
      .PERIOD_CYC (500000),
      .EN_CYC     (25000),
      .FILT_DEPTH (1)
   ) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_b),
      .dbg_state (dbg_b)
   );

   int total = 0;
   int bad   = 0;

   // ------------------------------------------------------------------------
   // Reference model: index 0 = dut_a, index 1 = dut_b
   // ------------------------------------------------------------------------
   logic [15:0] m_ir   [2];
   int          m_run  [2][16];
   logic [15:0] e_rise [2];
   logic [15:0] e_fall [2];

   // observed results captured at a sample_vld
   logic [2:0] oa_ir, oa_rise, oa_fall;
   logic [7:0] ob_ir, ob_rise, ob_fall;

   function automatic void model_clear();
      for (int u = 0; u < 2; u++) begin
         m_ir[u]   = '0;
         e_rise[u] = '0;
         e_fall[u] = '0;
         for (int c = 0; c < 16; c++) m_run[u][c] = 0;
      end
   endfunction

   // One sampling event: lvl is the active-high level seen by each channel.
   function automatic void model_sample(input int u, input int d, input int n,
                                        input logic [15:0] lvl,
                                        input logic [15:0] mask);
      logic [15:0] differ;
      differ    = (lvl ^ m_ir[u]) & mask;
      e_rise[u] = '0;
      e_fall[u] = '0;
      for (int c = 0; c < n; c++) begin
         if (!mask[c]) begin
            m_ir[u][c]  = 1'b0;
            m_run[u][c] = 0;
         end else if (!differ[c]) begin
            m_run[u][c] = 0;
         end else begin
            m_run[u][c] = m_run[u][c] + 1;
            if (m_run[u][c] >= d) begin
               e_rise[u][c] = lvl[c];
               e_fall[u][c] = !lvl[c];
               m_ir[u][c]   = lvl[c];
               m_run[u][c]  = 0;
            end
         end
      end
   endfunction

   // ------------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------------
   task automatic do_reset(input logic [7:0] nb);
      @(negedge clk);
      rst_n              = 1'b0;
      bus_a.ir_n         = '1;
      bus_a.en_mask      = '1;
      bus_a.force_sample = 1'b0;
      bus_b.ir_n         = nb;
      bus_b.en_mask      = '1;
      bus_b.force_sample = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_clear();
   endtask

   // Apply inputs for one period, wait for the next sample_vld of dut_a,
   // capture both instances' results and advance the model.
   task automatic step(input logic [2:0] na, input logic [2:0] ma,
                       input logic [7:0] nb, input logic [7:0] mb,
                       output bit to);
      bus_a.ir_n    = na;
      bus_a.en_mask = ma;
      bus_b.ir_n    = nb;
      bus_b.en_mask = mb;
      to = 1'b1;
      for (int i = 0; i < P + 20; i++) begin
         @(negedge clk);
         if (bus_a.sample_vld) begin
            to = 1'b0;
            break;
         end
      end
      oa_ir   = bus_a.ir;
      oa_rise = bus_a.ir_rise;
      oa_fall = bus_a.ir_fall;
      ob_ir   = bus_b.ir;
      ob_rise = bus_b.ir_rise;
      ob_fall = bus_b.ir_fall;
      model_sample(0, 2, 3, {13'b0, ~na}, {13'b0, ma});
      model_sample(1, 1, 8, {8'b0, ~nb}, {8'b0, mb});
   endtask

   // ------------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst_n              = 1'b0;
      bus_a.ir_n         = '1;
      bus_a.en_mask      = '1;
      bus_a.force_sample = 1'b0;
      bus_b.ir_n         = '1;
      bus_b.en_mask      = '1;
      bus_b.force_sample = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({bus_a.IR_en, bus_a.ir, bus_a.ir_rise, bus_a.ir_fall, bus_a.sample_vld, dbg_a} !== 13'b0) begin
         bad++;
         $display("FAIL reset_a: en=%b ir=%b rise=%b fall=%b vld=%b st=%0d need all 0",
                  bus_a.IR_en, bus_a.ir, bus_a.ir_rise, bus_a.ir_fall, bus_a.sample_vld, dbg_a);
      end
      total++;
      if ({bus_b.IR_en, bus_b.ir, bus_b.ir_rise, bus_b.ir_fall, bus_b.sample_vld, dbg_b} !== 28'b0) begin
         bad++;
         $display("FAIL reset_b: en=%b ir=%h rise=%h fall=%h vld=%b st=%0d need all 0",
                  bus_b.IR_en, bus_b.ir, bus_b.ir_rise, bus_b.ir_fall, bus_b.sample_vld, dbg_b);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_window();
      int prints = 0;
      do_reset(8'hFF);
      for (int k = 1; k <= 2 * P + 40; k++) begin
         logic exp_en, exp_vld;
         @(negedge clk);
         exp_en  = (k % P) >= (P - E);
         exp_vld = (k % P) == 0;
         total++;
         if (bus_a.IR_en !== exp_en || bus_a.sample_vld !== exp_vld || bus_a.ir !== 3'b000) begin
            bad++;
            if (prints < 5) begin
               prints++;
               $display("FAIL window k=%0d: en=%b vld=%b ir=%b need en=%b vld=%b ir=000",
                        k, bus_a.IR_en, bus_a.sample_vld, bus_a.ir, exp_en, exp_vld);
            end
         end
      end
   endtask

   task automatic test_debounce();
      logic [2:0] seq [6];
      bit to;
      seq = '{3'b101, 3'b101, 3'b111, 3'b111, 3'b101, 3'b111};
      do_reset(8'hFF);
      for (int i = 0; i < 6; i++) begin
         step(seq[i], 3'b111, 8'hFF, 8'hFF, to);
         total++;
         if (to || oa_ir !== m_ir[0][2:0] || oa_rise !== e_rise[0][2:0] || oa_fall !== e_fall[0][2:0]) begin
            bad++;
            $display("FAIL debounce s%0d: to=%0d ir=%b rise=%b fall=%b need ir=%b rise=%b fall=%b",
                     i, to, oa_ir, oa_rise, oa_fall, m_ir[0][2:0], e_rise[0][2:0], e_fall[0][2:0]);
         end
         if (i == 1) begin
            total++;
            if (oa_ir[1] !== 1'b1 || oa_rise[1] !== 1'b1) begin
               bad++;
               $display("FAIL debounce_2nd: ir1=%b rise1=%b need 1 1", oa_ir[1], oa_rise[1]);
            end
         end
         @(negedge clk);
         total++;
         if (bus_a.ir_rise !== 3'b000 || bus_a.ir_fall !== 3'b000) begin
            bad++;
            $display("FAIL debounce_pulse s%0d: rise=%b fall=%b need 000 000",
                     i, bus_a.ir_rise, bus_a.ir_fall);
         end
      end
   endtask

   task automatic test_glitch();
      do_reset(8'hFF);
      for (int p = 0; p < 3; p++) begin
         bit seen = 1'b0;
         repeat (100) @(negedge clk);
         bus_a.ir_n[0] = 1'b0;
         repeat (10) @(negedge clk);
         bus_a.ir_n[0] = 1'b1;
         for (int i = 0; i < P; i++) begin
            @(negedge clk);
            if (bus_a.sample_vld) begin
               seen = 1'b1;
               break;
            end
         end
         total++;
         if (!seen || bus_a.ir !== 3'b000) begin
            bad++;
            $display("FAIL glitch p%0d: seen=%0d ir=%b need seen=1 ir=000", p, seen, bus_a.ir);
         end
      end
   endtask

   task automatic test_mask();
      logic [2:0] msk [5];
      bit to;
      msk = '{3'b111, 3'b111, 3'b011, 3'b111, 3'b111};
      do_reset(8'hFF);
      for (int i = 0; i < 5; i++) begin
         step(3'b011, msk[i], 8'hFF, 8'hFF, to);
         total++;
         if (to || oa_ir !== m_ir[0][2:0] || oa_rise !== e_rise[0][2:0] || oa_fall !== e_fall[0][2:0]) begin
            bad++;
            $display("FAIL mask s%0d: to=%0d ir=%b rise=%b fall=%b need ir=%b rise=%b fall=%b",
                     i, to, oa_ir, oa_rise, oa_fall, m_ir[0][2:0], e_rise[0][2:0], e_fall[0][2:0]);
         end
         if (i == 2) begin
            total++;
            if (oa_ir[2] !== 1'b0 || oa_fall[2] !== 1'b0) begin
               bad++;
               $display("FAIL mask_clear: ir2=%b fall2=%b need 0 0", oa_ir[2], oa_fall[2]);
            end
         end
         if (i == 4) begin
            total++;
            if (oa_ir[2] !== 1'b1 || oa_rise[2] !== 1'b1) begin
               bad++;
               $display("FAIL mask_reenable: ir2=%b rise2=%b need 1 1", oa_ir[2], oa_rise[2]);
            end
         end
      end
   endtask

   task automatic test_force();
      bit to;
      int prints = 0;
      do_reset(8'hFF);
      step(3'b111, 3'b111, 8'hFF, 8'hFF, to);
      total++;
      if (to) begin
         bad++;
         $display("FAIL force_sync: no sample_vld within %0d cycles", P + 20);
      end
      repeat (100) @(negedge clk);
      bus_a.force_sample = 1'b1;
      // j counts clock edges after the request edge; the request moves the
      // counter to the window start, so the counter is (P-E-1+j) mod P.
      // Extra requests at j=10 (window on) and j=32 (sampling cycle) must
      // be ignored.
      for (int j = 1; j <= E + (P - E) + 48; j++) begin
         int   c;
         logic exp_en, exp_vld;
         @(negedge clk);
         bus_a.force_sample = (j == 10) || (j == E);
         c       = (P - E - 1 + j) % P;
         exp_en  = c >= (P - E);
         exp_vld = c == 0;
         total++;
         if (bus_a.IR_en !== exp_en || bus_a.sample_vld !== exp_vld || bus_a.ir !== 3'b000) begin
            bad++;
            if (prints < 5) begin
               prints++;
               $display("FAIL force j=%0d: en=%b vld=%b ir=%b need en=%b vld=%b ir=000",
                        j, bus_a.IR_en, bus_a.sample_vld, bus_a.ir, exp_en, exp_vld);
            end
         end
      end
      bus_a.force_sample = 1'b0;
   endtask

   task automatic test_wide();
      bit to;
      do_reset(8'hA5);
      step(3'b111, 3'b111, 8'hA5, 8'hFF, to);
      total++;
      if (to || ob_ir !== 8'h5A || ob_rise !== 8'h5A || ob_fall !== 8'h00) begin
         bad++;
         $display("FAIL wide_first: to=%0d ir=%h rise=%h fall=%h need ir=5a rise=5a fall=00",
                  to, ob_ir, ob_rise, ob_fall);
      end
      @(negedge clk);
      total++;
      if (bus_b.ir !== 8'h5A || bus_b.ir_rise !== 8'h00) begin
         bad++;
         $display("FAIL wide_pulse: ir=%h rise=%h need ir=5a rise=00", bus_b.ir, bus_b.ir_rise);
      end
   endtask

   task automatic test_random();
      logic [2:0] na, ma;
      logic [7:0] nb, mb;
      bit to;
      na = 3'b111;
      nb = 8'hFF;
      do_reset(8'hFF);
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 1) == 1) na = 3'($urandom);
         if ($urandom_range(0, 1) == 1) nb = 8'($urandom);
         ma = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
         mb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         step(na, ma, nb, mb, to);
         total++;
         if (to || oa_ir !== m_ir[0][2:0] || oa_rise !== e_rise[0][2:0] || oa_fall !== e_fall[0][2:0]) begin
            bad++;
            $display("FAIL random_a s%0d: to=%0d ir=%b rise=%b fall=%b need ir=%b rise=%b fall=%b",
                     i, to, oa_ir, oa_rise, oa_fall, m_ir[0][2:0], e_rise[0][2:0], e_fall[0][2:0]);
         end
         total++;
         if (ob_ir !== m_ir[1][7:0] || ob_rise !== e_rise[1][7:0] || ob_fall !== e_fall[1][7:0]) begin
            bad++;
            $display("FAIL random_b s%0d: ir=%h rise=%h fall=%h need ir=%h rise=%h fall=%h",
                     i, ob_ir, ob_rise, ob_fall, m_ir[1][7:0], e_rise[1][7:0], e_fall[1][7:0]);
         end
      end
   endtask

   task automatic test_reset_mid_window();
      bit to;
      bit seen = 1'b0;
      do_reset(8'hFF);
      step(3'b101, 3'b111, 8'hFF, 8'hFF, to);
      step(3'b101, 3'b111, 8'hFF, 8'hFF, to);
      total++;
      if (to || bus_a.ir !== 3'b010) begin
         bad++;
         $display("FAIL midrst_setup: to=%0d ir=%b need ir=010", to, bus_a.ir);
      end
      for (int i = 0; i < P; i++) begin
         @(negedge clk);
         if (bus_a.IR_en) begin
            seen = 1'b1;
            break;
         end
      end
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (!seen || bus_a.IR_en !== 1'b0 || bus_a.ir !== 3'b000 || bus_a.sample_vld !== 1'b0) begin
         bad++;
         $display("FAIL midrst: seen=%0d en=%b ir=%b vld=%b need seen=1 en=0 ir=000 vld=0",
                  seen, bus_a.IR_en, bus_a.ir, bus_a.sample_vld);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   // Sequence and report
   // ------------------------------------------------------------------------
   initial begin
      test_reset();
      test_window();
      test_debounce();
      test_glitch();
      test_mask();
      test_force();
      test_wide();
      test_random();
      test_reset_mid_window();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ir_intf_mc.md
# ir_intf_mc

Parametrised multi-channel IR sensor interface, the generalised successor to the three-channel IR front end in the Knight's Tour robot. It duty-cycles the shared IR emitter enable, samples up to NUM_CH active-low detector inputs at the end of each enable window, and filters each channel with a configurable consecutive-sample debounce. It produces per-channel level, rise and fall outputs for `cmd_proc` and `inert_intf`. Adds features the fixed-function block lacks: channel masking, on-demand forced sampling, and a sample-valid strobe.

## Interface
- FAST_SIM, default 1: when 1, the period is 512 cycles and the enable window is 32 cycles; when 0, PERIOD_CYC and EN_CYC are used.
- NUM_CH, default 3: number of IR channels, 1..16.
- PERIOD_CYC, default 500000: sample period in clocks (10 ms at 50 MHz).
- EN_CYC, default 25000: emitter-on window in clocks (500 µs). Must satisfy 2 ≤ EN_CYC < PERIOD_CYC.
- FILT_DEPTH, default 2: number of consecutive disagreeing samples required to change an output, 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ir_n  in  NUM_CH  raw detector inputs, active-low, asynchronous.
- en_mask  in  NUM_CH  1 = channel enabled.
- force_sample  in  1  single-cycle pulse requesting an early window.
- IR_en  out  1  emitter enable (registered).
- ir  out  NUM_CH  filtered levels, active-high.
- ir_rise  out  NUM_CH  one-cycle pulse when ir goes 0→1.
- ir_fall  out  NUM_CH  one-cycle pulse when ir goes 1→0.
- sample_vld  out  1  one-cycle pulse marking the cycle in which the filter results update.

## Operation
- **Synchronisation:** ir_n passes through a 2-flop synchroniser, then is inverted to form s[c].
- **Period counter:** cnt runs 0..P-1, where P is the effective period, then wraps to 0.
  - IR_en = 1 exactly when cnt ≥ P-E, where E is the effective enable window.
  - IR_en is registered, decoded from the next cnt value.
- **State machine:**
  - OFF when cnt < P-E.
  - ON when P-E ≤ cnt < P-1.
  - SAMP when cnt = P-1.
  - SAMP always returns to OFF with cnt = 0.
- **Forced sample:** force_sample in OFF loads cnt = P-E, entering ON on the next cycle. force_sample in ON or SAMP is ignored.
- **Filter,** evaluated per channel at the SAMP clock edge (disagreement counter dc[c], 4 bits):
  - en_mask[c] = 0: ir[c] ← 0 and dc[c] ← 0. No rise or fall pulse is generated for a mask-induced clear.
  - s[c] == ir[c]: dc[c] ← 0.
  - Otherwise dc[c] ← dc[c]+1. When dc[c]+1 == FILT_DEPTH, ir[c] toggles, dc[c] ← 0, and the matching rise or fall bit pulses.
- **Output timing:** ir, ir_rise, ir_fall and sample_vld all change on the same edge. sample_vld is high only in the cycle after SAMP, i.e. cnt = 0.
- **Input changes:** en_mask changes take effect only at the next SAMP. Input glitches between samples are ignored.

## Timing
- **Reset values:** cnt = 0, state OFF, IR_en = 0, ir = 0, ir_rise = 0, ir_fall = 0, sample_vld = 0, dc = 0, synchroniser flops = 1 (inactive).
- **First window after reset:** IR_en rises at the clock where cnt becomes P-E, i.e. after P-E cycles.
- **Window length:** IR_en is high for exactly E cycles per period.
- **Natural sample:** sampling happens in the last high cycle. sample_vld and output updates appear one cycle after IR_en falls… more precisely, on the same edge on which IR_en falls.
- **Input-to-output latency:**
  - Synchroniser: 2 cycles.
  - The input must be stable by cnt = P-3 to be seen at SAMP.
  - An output change needs FILT_DEPTH consecutive periods.
- **Forced sample:** IR_en rises on the cycle after force_sample, and sample_vld follows E cycles later. The period counter continues from 0 afterwards, so the natural phase shifts.
- **Overlap:** force_sample coincident with SAMP is ignored.
- **Reset mid-window:** IR_en drops immediately (asynchronously), and filter state is lost.

## Test plan
1. **Reset and window timing** (FAST_SIM=1, ir_n all high).
   - Stimulus: release reset.
   - Required: IR_en high for cycles 480..511 of each period; sample_vld pulses every 512 cycles; ir stays 0.
2. **Debounce** (FILT_DEPTH=2).
   - Stimulus: ir_n[1] held low.
   - Required: ir[1] rises at the 2nd sample_vld, with a single ir_rise[1] pulse there.
   - Stimulus: ir_n[1] low for only one sample.
   - Required: no change in ir[1].
3. **Glitch rejection.**
   - Stimulus: pulse ir_n[0] low for 10 cycles during OFF, returning high before the window.
   - Required: no dc change; ir[0] remains 0 indefinitely.
4. **Mask.**
   - Stimulus: with ir[2] = 1, clear en_mask[2].
   - Required: at the next sample_vld, ir[2] = 0 and ir_fall[2] = 0.
   - Stimulus: re-enable with the input still low.
   - Required: ir[2] returns to 1 after FILT_DEPTH samples, with an ir_rise[2] pulse.
5. **Forced sample.**
   - Stimulus: force_sample at cnt = 100.
   - Required: IR_en high on the next cycle for 32 cycles, sample_vld 32 cycles after the request, then the next window 480 cycles after the return to OFF.
   - Stimulus: force_sample during ON.
   - Required: no effect.
6. **Wide configuration** (NUM_CH=8, FILT_DEPTH=1, ir_n = 8'hA5).
   - Required: ir = 8'h5A at the first sample_vld, and ir_rise = 8'h5A for one cycle.
